// File: rtl/mlow_packet_deframer.sv
// Receive-side packet deframer: validates sync, length and XOR checksum, then presents one frame.
// Optional sequence-gap counting is built when MLOW_DEFRAMER_SEQ_CHECK_EN is defined.
module mlow_packet_deframer #(
  parameter int unsigned FRAME_SAMPLES = 16,
  parameter logic [3:0]  SYNC_NIBBLE   = 4'hA
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [7:0]                  packet_data_i,
  input  logic                        packet_valid_i,
  output logic                        packet_ready_o,
  input  logic                        packet_start_i,
  input  logic                        packet_end_i,
  output logic [16*FRAME_SAMPLES-1:0] frame_data_bus_o,
  output logic [15:0]                 frame_data_o,
  output logic                        frame_valid_o,
  input  logic                        frame_ready_i,
  output logic                        error_o,
  output logic [1:0]                  err_code_o,
  output logic [15:0]                 frames_ok_o,
  output logic [15:0]                 frames_bad_o,
  output logic [7:0]                  seq_gap_o
);

  localparam int unsigned PayloadBytes = 2 * FRAME_SAMPLES;
  localparam int unsigned IdxW         = (PayloadBytes > 1) ? $clog2(PayloadBytes) : 1;
  localparam int unsigned BusW         = 16 * FRAME_SAMPLES;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PayloadBytes - 1);

  localparam logic [1:0] ErrSync = 2'd1;
  localparam logic [1:0] ErrLen  = 2'd2;
  localparam logic [1:0] ErrCsum = 2'd3;

  typedef enum logic [2:0] {StIdle, StPayload, StCsum, StHold, StDiscard} state_e;

  state_e            r_state_q, w_state_d;
  logic [7:0]        r_csum_q, w_csum_d;
  logic [IdxW-1:0]   r_idx_q, w_idx_d;
  logic [BusW-1:0]   r_bus_q, w_bus_d;
  logic              r_ready_q;
  logic              r_error_q;
  logic [1:0]        r_err_code_q;
  logic [15:0]       r_ok_q;
  logic [15:0]       r_bad_q;

  logic              w_accept;
  logic              w_sync_ok;
  logic              w_do_hdr;
  logic              w_err_a;
  logic              w_err_b;
  logic [1:0]        w_code_a;
  logic [1:0]        w_code_b;
  logic              w_deliver;
  logic [IdxW-1:0]   w_lane;

  assign w_accept  = packet_valid_i && r_ready_q;
  assign w_sync_ok = (packet_data_i[7:4] == SYNC_NIBBLE);
  // Even payload bytes are sample MSBs, so they land in the upper byte lane of the sample.
  assign w_lane    = r_idx_q ^ IdxW'(1);

  // w_err_a flags the packet being abandoned; w_err_b flags a rejected header on the same byte.
  always_comb begin
    w_state_d = r_state_q;
    w_csum_d  = r_csum_q;
    w_idx_d   = r_idx_q;
    w_bus_d   = r_bus_q;
    w_do_hdr  = 1'b0;
    w_err_a   = 1'b0;
    w_err_b   = 1'b0;
    w_code_a  = ErrLen;
    w_code_b  = ErrLen;
    w_deliver = 1'b0;

    unique case (r_state_q)
      StIdle: begin
        if (w_accept && packet_start_i) w_do_hdr = 1'b1;
      end
      StPayload: begin
        if (w_accept) begin
          if (packet_start_i) begin
            w_err_a  = 1'b1;
            w_do_hdr = 1'b1;
          end else if (packet_end_i) begin
            w_err_a   = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_bus_d[{w_lane, 3'b000} +: 8] = packet_data_i;
            w_csum_d = r_csum_q ^ packet_data_i;
            w_idx_d  = r_idx_q + 1'b1;
            if (r_idx_q == LastIdx) w_state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (w_accept) begin
          if (packet_start_i) begin
            w_err_a  = 1'b1;
            w_do_hdr = 1'b1;
          end else if (!packet_end_i) begin
            w_err_a   = 1'b1;
            w_state_d = StDiscard;
          end else if (packet_data_i != r_csum_q) begin
            w_err_a   = 1'b1;
            w_code_a  = ErrCsum;
            w_state_d = StIdle;
          end else begin
            w_state_d = StHold;
          end
        end
      end
      StHold: begin
        if (frame_ready_i) begin
          w_deliver = 1'b1;
          w_state_d = StIdle;
        end
      end
      StDiscard: begin
        if (w_accept) begin
          if (packet_start_i) w_do_hdr = 1'b1;
          else if (packet_end_i) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_do_hdr) begin
      if (packet_end_i) begin
        w_err_b   = 1'b1;
        w_state_d = StIdle;
      end else if (!w_sync_ok) begin
        w_err_b   = 1'b1;
        w_code_b  = ErrSync;
        w_state_d = StDiscard;
      end else begin
        w_csum_d  = packet_data_i;
        w_idx_d   = '0;
        w_state_d = StPayload;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state_q    <= StIdle;
      r_csum_q     <= '0;
      r_idx_q      <= '0;
      r_bus_q      <= '0;
      r_ready_q    <= 1'b0;
      r_error_q    <= 1'b0;
      r_err_code_q <= '0;
      r_ok_q       <= '0;
      r_bad_q      <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_csum_q  <= w_csum_d;
      r_idx_q   <= w_idx_d;
      r_bus_q   <= w_bus_d;
      r_ready_q <= (w_state_d != StHold);
      r_error_q <= w_err_a || w_err_b;
      if (w_err_b)      r_err_code_q <= w_code_b;
      else if (w_err_a) r_err_code_q <= w_code_a;
      if (w_deliver) r_ok_q <= r_ok_q + 16'd1;
      r_bad_q <= r_bad_q + 16'(w_err_a) + 16'(w_err_b);
    end
  end

`ifdef MLOW_DEFRAMER_SEQ_CHECK_EN
  logic       w_hdr_ok;
  logic [3:0] r_seq_q;
  logic [3:0] r_last_seq_q;
  logic       r_have_base_q;
  logic [7:0] r_gap_q;

  assign w_hdr_ok = w_do_hdr && !packet_end_i && w_sync_ok;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_seq_q       <= '0;
      r_last_seq_q  <= '0;
      r_have_base_q <= 1'b0;
      r_gap_q       <= '0;
    end else begin
      if (w_hdr_ok) r_seq_q <= packet_data_i[3:0];
      if (w_deliver) begin
        if (r_have_base_q && (r_seq_q != r_last_seq_q + 4'd1) && (r_gap_q != 8'hFF)) begin
          r_gap_q <= r_gap_q + 8'd1;
        end
        r_last_seq_q  <= r_seq_q;
        r_have_base_q <= 1'b1;
      end
    end
  end

  assign seq_gap_o = r_gap_q;
`else
  assign seq_gap_o = '0;
`endif

  assign packet_ready_o   = r_ready_q;
  assign frame_valid_o    = (r_state_q == StHold);
  assign frame_data_bus_o = r_bus_q;
  assign frame_data_o     = r_bus_q[15:0];
  assign error_o          = r_error_q;
  assign err_code_o       = r_err_code_q;
  assign frames_ok_o      = r_ok_q;
  assign frames_bad_o     = r_bad_q;

endmodule
